// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg: control/data inputs from the master, register
// contents and burst status back from the shifter.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             EN;
    logic [2:0]       MODE;
    logic [WIDTH-1:0] D;
    logic             SIL;
    logic             SIR;
    logic             START;
    logic [CW-1:0]    COUNT;
    logic [WIDTH-1:0] Q;
    logic             SO_L;
    logic             SO_R;
    logic             BUSY;
    logic             DONE;

    modport master (
        output EN, MODE, D, SIL, SIR, START, COUNT,
        input  Q, SO_L, SO_R, BUSY, DONE
    );

    modport slave (
        input  EN, MODE, D, SIL, SIR, START, COUNT,
        output Q, SO_L, SO_R, BUSY, DONE
    );
endinterface

// File: rtl/univ_shift_reg.sv
// General-purpose WIDTH-bit register/shifter with single-step modes and a
// counted burst-shift engine reporting BUSY/DONE.
//
// state   | meaning
// S_IDLE  | MODE applied once per enabled edge; START with a shift mode opens a burst
// S_BURST | latched mode applied once per enabled edge until the step count expires
module univ_shift_reg #(
    parameter int               WIDTH = 8,
    parameter int               CW    = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    univ_shift_reg_if.slave bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cnt_last;

    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d,
        input logic             sil,
        input logic             sir
    );
        case (m)
            3'b000:  return q;
            3'b001:  return d;
            3'b010:  return {q[WIDTH-2:0], sir};
            3'b011:  return {sil, q[WIDTH-1:1]};
            3'b100:  return {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101:  return {q[0], q[WIDTH-1:1]};
            3'b110:  return {q[WIDTH-1], q[WIDTH-1:1]};
            default: return '0;
        endcase
    endfunction

    function automatic logic is_shift(input logic [2:0] m);
        return (m >= 3'b010) && (m <= 3'b110);
    endfunction

    // A zero-count burst still spends one enabled edge in S_BURST before DONE.
    assign cnt_last = (cnt_q == '0) || (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.EN) begin
                    if (bus.START && is_shift(bus.MODE)) begin
                        state_d = S_BURST;
                        mode_d  = bus.MODE;
                        cnt_d   = bus.COUNT;
                        busy_d  = 1'b1;
                    end else begin
                        q_d = apply_mode(bus.MODE, q_q, bus.D, bus.SIL, bus.SIR);
                    end
                end
            end
            S_BURST: begin
                if (bus.EN) begin
                    if (cnt_q != '0) begin
                        q_d   = apply_mode(mode_q, q_q, bus.D, bus.SIL, bus.SIR);
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (cnt_last) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            q_q     <= INIT;
            mode_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q    = q_q;
    assign bus.SO_L = q_q[WIDTH-1];
    assign bus.SO_R = q_q[0];
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus random traffic, all checked
// cycle by cycle against an arithmetic reference model.
module tb_univ_shift_reg;
    localparam int W  = 8;
    localparam int CW = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    univ_shift_reg_if #(.WIDTH(W), .CW(CW)) bus ();

    univ_shift_reg #(.WIDTH(W), .CW(CW), .INIT(8'hA5)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_q;
    bit m_busy;
    bit m_done;
    int m_mode;
    int m_count;
    int m_edges;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int op(input int mode, input int q, input int d, input int sil, input int sir);
        case (mode)
            0:       return q;
            1:       return d;
            2:       return (q * 2) % 256 + sir;
            3:       return q / 2 + sil * 128;
            4:       return (q * 2) % 256 + q / 128;
            5:       return q / 2 + (q % 2) * 128;
            6:       return q / 2 + (q / 128) * 128;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_q = 'hA5; m_busy = 0; m_done = 0; m_mode = 0; m_count = 0; m_edges = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!bus.EN) return;
        if (!m_busy) begin
            if (bus.START && bus.MODE >= 2 && bus.MODE <= 6) begin
                m_busy  = 1;
                m_mode  = int'(bus.MODE);
                m_count = int'(bus.COUNT);
                m_edges = 0;
            end else begin
                m_q = op(int'(bus.MODE), m_q, int'(bus.D), int'(bus.SIL), int'(bus.SIR));
            end
        end else begin
            if (m_edges < m_count)
                m_q = op(m_mode, m_q, 0, int'(bus.SIL), int'(bus.SIR));
            m_edges++;
            if (m_edges >= ((m_count == 0) ? 1 : m_count)) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask

    task automatic compare_all();
        check("q",    bus.Q,    m_q);
        check("busy", bus.BUSY, m_busy);
        check("done", bus.DONE, m_done);
        check("so_l", bus.SO_L, m_q / 128);
        check("so_r", bus.SO_R, m_q % 2);
    endtask

    task automatic drive(input bit en, input int mode, input int d, input bit sil, input bit sir,
                         input bit start, input int count);
        bus.EN    = en;
        bus.MODE  = 3'(mode);
        bus.D     = 8'(d);
        bus.SIL   = sil;
        bus.SIR   = sir;
        bus.START = start;
        bus.COUNT = 4'(count);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_q_init", bus.Q, 8'hA5);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        do_reset();

        // single operations
        drive(1, 1, 'h81, 0, 0, 0, 0); cycle(); check("load", bus.Q, 8'h81);
        drive(1, 4, 0, 0, 0, 0, 0);    cycle(); check("rotl", bus.Q, 8'h03);
        drive(1, 1, 'h80, 0, 0, 0, 0); cycle();
        drive(1, 6, 0, 0, 0, 0, 0);    cycle(); check("asr", bus.Q, 8'hC0);
        drive(1, 1, 'h00, 0, 0, 0, 0); cycle();
        drive(1, 2, 0, 0, 1, 0, 0);    cycle(); check("shl_sir", bus.Q, 8'h01);
        drive(1, 7, 0, 0, 0, 0, 0);    cycle(); check("clear", bus.Q, 8'h00);
        drive(1, 0, 0, 0, 0, 0, 0);    cycle();

        // burst of 3 left shifts, MODE scrambled while busy
        drive(1, 1, 'h01, 0, 0, 0, 0); cycle();
        drive(1, 2, 0, 0, 0, 1, 3);    cycle(); check("burst_acc_q", bus.Q, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1, 7 - i, 'hFF, 1, 0, 0, 9);
            cycle();
        end
        check("burst_q", bus.Q, 8'h08);
        check("burst_done", bus.DONE, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0); cycle(); check("burst_done_off", bus.DONE, 1'b0);

        // same burst with a 2-cycle stall in the middle
        drive(1, 1, 'h01, 0, 0, 0, 0); cycle();
        drive(1, 2, 0, 0, 0, 1, 3);    cycle();
        drive(1, 0, 0, 0, 0, 0, 0);    cycle();
        drive(0, 0, 0, 0, 0, 0, 0);    cycle(); cycle(); check("stall_q", bus.Q, 8'h02);
        drive(1, 0, 0, 0, 0, 0, 0);    cycle(); cycle();
        check("stall_q_final", bus.Q, 8'h08);
        cycle();

        // zero-count burst
        drive(1, 3, 0, 1, 1, 1, 0); cycle(); check("cnt0_busy", bus.BUSY, 1'b1);
        drive(1, 0, 0, 0, 0, 0, 0); cycle(); check("cnt0_q", bus.Q, 8'h08);
        cycle();

        // START held while busy and through the DONE cycle
        drive(1, 5, 0, 0, 0, 1, 2);
        for (int i = 0; i < 8; i++) cycle();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();

        // reset mid-burst
        drive(1, 4, 0, 0, 0, 1, 9); cycle();
        drive(1, 0, 0, 0, 0, 0, 0); cycle(); cycle();
        do_reset();
        cycle();

        // random traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 9) != 0), $urandom_range(0, 7), $urandom_range(0, 255),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
